// File: rtl/mesh_inject_scheduler_if.sv
// Requester and router P-link handshake bundle for mesh_inject_scheduler.
// req_*: local sources (valid/data in, yumi out); link_*: valid/ready_and toward router.
interface mesh_inject_scheduler_if #(
   parameter int num_req_p = 4,
   parameter int width_p   = 38
);
   logic [num_req_p-1:0]              req_v;
   logic [num_req_p-1:0][width_p-1:0] req_data;
   logic [num_req_p-1:0]              req_yumi;
   logic                              link_v;
   logic [width_p-1:0]                link_data;
   logic                              link_ready_and;

   modport master (
      input  req_v, req_data, link_ready_and,
      output req_yumi, link_v, link_data
   );

   modport slave (
      output req_v, req_data, link_ready_and,
      input  req_yumi, link_v, link_data
   );
endinterface

// File: rtl/mesh_inject_scheduler.sv
// Round-robin injection scheduler with one-entry output register and credit limit.
// Ports: clk_i, reset_n_i, bus (requesters + P link), credit_return_i, credits_o,
//   sent_count_o, overflow_o (sticky credit overflow), idle_o.
module mesh_inject_scheduler #(
   parameter int num_req_p     = 4,
   parameter int width_p       = 38,
   parameter int credits_p     = 8,
   parameter int count_width_p = 16,
   localparam int cw           = $clog2(credits_p + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   mesh_inject_scheduler_if.master  bus,
   input  logic                     credit_return_i,
   output logic [cw-1:0]            credits_o,
   output logic [count_width_p-1:0] sent_count_o,
   output logic                     overflow_o,
   output logic                     idle_o
);
   localparam int pw = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   logic [pw-1:0]      rr_ptr;
   logic [pw-1:0]      winner;
   logic [pw-1:0]      idx;
   logic [pw-1:0]      ptr_next;
   logic               found;
   logic               link_v;
   logic [width_p-1:0] link_data;
   logic               fire;
   logic               load_en;

   assign bus.link_v    = link_v;
   assign bus.link_data = link_data;

   // Search starting at rr_ptr, wrapping; first valid requester wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < num_req_p; k++) begin
         idx = pw'((int'(rr_ptr) + k) % num_req_p);
         if (!found && bus.req_v[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign ptr_next = (int'(winner) == num_req_p - 1) ? '0 : winner + 1'b1;

   assign fire    = link_v & bus.link_ready_and;
   // Credits returned this cycle are not usable until the next one.
   assign load_en = (!link_v | fire) & (credits_o != '0) & (|bus.req_v);

   assign bus.req_yumi = (load_en & reset_n_i)
                       ? (num_req_p'(1) << winner) : '0;

   assign idle_o = !link_v & (credits_o == cw'(credits_p));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         link_v       <= 1'b0;
         link_data    <= '0;
         rr_ptr       <= '0;
         credits_o    <= cw'(credits_p);
         sent_count_o <= '0;
         overflow_o   <= 1'b0;
      end else begin
         if (load_en) begin
            link_v    <= 1'b1;
            link_data <= bus.req_data[winner];
            rr_ptr    <= ptr_next;
         end else if (fire) begin
            link_v <= 1'b0;
         end

         if (fire)
            sent_count_o <= sent_count_o + count_width_p'(1);

         if (load_en && !credit_return_i) begin
            credits_o <= credits_o - 1'b1;
         end else if (!load_en && credit_return_i) begin
            if (credits_o == cw'(credits_p))
               overflow_o <= 1'b1;
            else
               credits_o <= credits_o + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mesh_inject_scheduler.sv
// Directed + randomized bench for mesh_inject_scheduler.
// A transaction-level reference model predicts yumi, link state and counters.
module tb_mesh_inject_scheduler;
   localparam int NR = 4;
   localparam int W  = 38;
   localparam int CR = 8;
   localparam int CW = 16;

   logic       clk;
   logic       reset_n_i;
   logic       credit_return_i;
   logic [3:0] credits_o;
   logic [CW-1:0] sent_count_o;
   logic       overflow_o;
   logic       idle_o;

   mesh_inject_scheduler_if #(.num_req_p(NR), .width_p(W)) bus ();

   mesh_inject_scheduler #(
      .num_req_p(NR), .width_p(W), .credits_p(CR), .count_width_p(CW)
   ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n_i),
      .bus(bus.master),
      .credit_return_i(credit_return_i),
      .credits_o(credits_o),
      .sent_count_o(sent_count_o),
      .overflow_o(overflow_o),
      .idle_o(idle_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit           m_v;
   logic [W-1:0] m_data;
   int           m_cred;
   int           m_cnt;
   bit           m_ovf;
   int           m_ptr;

   int grants[NR];
   int yumi_tot;
   int last_win;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_v    = 0;
      m_data = '0;
      m_cred = CR;
      m_cnt  = 0;
      m_ovf  = 0;
      m_ptr  = 0;
   endtask

   task automatic drive(input logic [NR-1:0] v, input bit rdy,
                        input bit ret);
      bus.req_v          = v;
      bus.link_ready_and = rdy;
      credit_return_i    = ret;
      for (int i = 0; i < NR; i++)
         bus.req_data[i] = W'({$urandom(), $urandom()});
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".link_v"}, 64'(bus.link_v), 64'(m_v));
      chk({tag, ".data"}, 64'(bus.link_data), 64'(m_data));
      chk({tag, ".credits"}, 64'(credits_o), 64'(m_cred));
      chk({tag, ".sent"}, 64'(sent_count_o), 64'(m_cnt));
      chk({tag, ".ovf"}, 64'(overflow_o), 64'(m_ovf));
      chk({tag, ".idle"}, 64'(idle_o), 64'(!m_v && m_cred == CR));
   endtask

   // One clock: check yumi before the edge, advance model, check after.
   task automatic cyc(input string tag);
      bit           ld;
      bit           fr;
      int           w;
      logic [NR-1:0] ey;
      logic [W-1:0] nd;
      #1;
      fr = m_v && bus.link_ready_and;
      w  = -1;
      for (int k = 0; k < NR; k++)
         if (w < 0 && bus.req_v[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      ld = (!m_v || fr) && m_cred > 0 && w >= 0;
      ey = ld ? NR'(1) << w : '0;
      nd = ld ? bus.req_data[w] : '0;
      chk({tag, ".yumi"}, 64'(bus.req_yumi), 64'(ey));
      for (int i = 0; i < NR; i++)
         if (bus.req_yumi[i]) begin
            grants[i]++;
            yumi_tot++;
            last_win = i;
         end
      @(posedge clk);
      if (ld) begin
         m_v    = 1;
         m_data = nd;
         m_ptr  = (w + 1) % NR;
      end else if (fr) begin
         m_v = 0;
      end
      if (fr) m_cnt = (m_cnt + 1) % (1 << CW);
      m_cred = m_cred - int'(ld) + int'(credit_return_i);
      if (m_cred > CR) begin
         m_cred = CR;
         m_ovf  = 1;
      end
      #1;
      chk_outs(tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      drive(4'b1111, 1'b1, 1'b0);
      model_reset();
      @(negedge clk);
      chk("rst.yumi", 64'(bus.req_yumi), 64'(0));
      chk_outs("rst");
      reset_n_i = 1'b1;
      for (int i = 0; i < NR; i++) grants[i] = 0;
      yumi_tot = 0;
   endtask

   initial begin
      int seq[3];
      logic [W-1:0] pkt_a;
      seq = '{3, 1, 3};
      reset_n_i = 1'b0;
      drive('0, 1'b0, 1'b0);
      do_reset();

      // credit exhaustion with one requester
      for (int c = 0; c < 10; c++) begin
         drive(4'b0001, 1'b1, 1'b0);
         cyc("single");
      end
      chk("single.yumis", 64'(yumi_tot), 64'(8));
      chk("single.cred0", 64'(credits_o), 64'(0));
      chk("single.sent8", 64'(sent_count_o), 64'(8));
      drive(4'b0001, 1'b1, 1'b1);
      cyc("single.ret");
      chk("single.noyumi_on_ret", 64'(yumi_tot), 64'(8));
      drive(4'b0001, 1'b1, 1'b0);
      cyc("single.after");
      chk("single.yumi_after_ret", 64'(yumi_tot), 64'(9));

      // fair rotation among four busy requesters
      do_reset();
      for (int c = 0; c < 100; c++) begin
         drive(4'b1111, 1'b1, 1'b1);
         cyc("rr4");
      end
      for (int i = 0; i < NR; i++)
         chk($sformatf("rr4.grants%0d", i), 64'(grants[i]), 64'(25));
      chk("rr4.noovf", 64'(overflow_o), 64'(0));

      // pointer skips empty slots
      do_reset();
      drive(4'b0010, 1'b1, 1'b0);
      cyc("skip.prime");
      for (int c = 0; c < 3; c++) begin
         drive(4'b1010, 1'b1, 1'b1);
         last_win = -1;
         cyc("skip");
         chk($sformatf("skip.win%0d", c), 64'(last_win), 64'(seq[c]));
      end

      // router stall holds packet A
      do_reset();
      drive(4'b1111, 1'b0, 1'b0);
      cyc("stall.load");
      pkt_a = m_data;
      for (int c = 0; c < 5; c++) begin
         drive(4'b1111, 1'b0, 1'b0);
         cyc("stall");
         chk("stall.hold", 64'(bus.link_data), 64'(pkt_a));
         chk("stall.cred", 64'(credits_o), 64'(7));
      end
      drive(4'b1111, 1'b1, 1'b0);
      #1;
      chk("stall.release_yumi", 64'(bus.req_yumi), 64'(4'b0010));
      cyc("stall.release");

      // simultaneous load and return, then overflow
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(4'b0001, 1'b1, 1'b0);
         cyc("cr.fill");
      end
      chk("cr.at3", 64'(credits_o), 64'(3));
      drive(4'b0001, 1'b1, 1'b1);
      cyc("cr.both");
      chk("cr.still3", 64'(credits_o), 64'(3));
      for (int c = 0; c < 6; c++) begin
         drive(4'b0000, 1'b1, 1'b1);
         cyc("cr.ret");
      end
      for (int c = 0; c < 3; c++) begin
         drive(4'b0000, 1'b1, 1'b0);
         cyc("cr.sticky");
      end
      chk("cr.ovf", 64'(overflow_o), 64'(1));
      chk("cr.full", 64'(credits_o), 64'(8));

      // randomized traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive(NR'($urandom()), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0);
         cyc("rand");
      end

      // asynchronous reset in mid-cycle
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(4'b0001, 1'b1, 1'b0);
         cyc("ar.fill");
      end
      chk("ar.pre_v", 64'(bus.link_v), 64'(1));
      chk("ar.pre_cred", 64'(credits_o), 64'(2));
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("ar.v", 64'(bus.link_v), 64'(0));
      chk("ar.cred", 64'(credits_o), 64'(8));
      chk("ar.sent", 64'(sent_count_o), 64'(0));
      chk("ar.ovf", 64'(overflow_o), 64'(0));
      chk("ar.idle", 64'(idle_o), 64'(1));
      chk("ar.yumi", 64'(bus.req_yumi), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
